// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter with a byte FIFO on a valid/ready input.
// Bit timing matches the loader's receiver clock-for-clock.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;

  logic push, pop, done, empty, bit_end;

  assign empty    = (count_q == '0);
  assign tx_ready = (count_q != FULL);
  assign push     = tx_valid && tx_ready;
  assign bit_end  = (baud_q == BAUD_MAX);

  assign uart_tx    = line_q;
  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = done;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          done   = 1'b1;
          // Chain straight into the next start bit when data is waiting
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d = mem[rd_ptr];
      bit_d   = '0;
    end
  end

  always_comb begin
    line_d = 1'b1;
    unique case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one instance at 32 clks/bit,
// one at the 2 clks/bit minimum, line samples decoded mid-bit.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy, a_done;
  logic [3:0] a_cnt;

  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy, b_done;
  logic [3:0] b_cnt;

  uart_tx_ctrl #(.CLKS_PER_BIT(32), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .uart_tx(a_tx), .tx_busy(a_busy), .tx_done(a_done),
    .fifo_count(a_cnt)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .uart_tx(b_tx), .tx_busy(b_busy), .tx_done(b_done),
    .fifo_count(b_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rec      = 1'b0;

  logic qa[$], qad[$], qab[$];
  logic qb[$], qbd[$], qbb[$];
  logic [7:0] rx[$];
  int st[$];
  int ferr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rec) begin
      qa.push_back(a_tx); qad.push_back(a_done); qab.push_back(a_busy);
      qb.push_back(b_tx); qbd.push_back(b_done); qbb.push_back(b_busy);
    end
  endtask

  task automatic start_rec();
    qa.delete(); qad.delete(); qab.delete();
    qb.delete(); qbd.delete(); qbb.delete();
    cyc = -1;
    rec = 1'b1;
  endtask

  task automatic wait_idle(input bit sel, input int budget, input string tag);
    int n;
    n = 0;
    while (n < budget &&
           (sel ? (b_busy !== 1'b0 || b_cnt != 0)
                : (a_busy !== 1'b0 || a_cnt != 0))) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 1);
    repeat (2) tick();
  endtask

  task automatic decode(input bit sel, input int c);
    logic q[$];
    logic [7:0] b;
    int i;
    if (sel) q = qb;
    else     q = qa;
    rx.delete();
    st.delete();
    ferr = 0;
    i = 1;
    while (i + 10*c <= q.size()) begin
      if (q[i-1] === 1'b1 && q[i] === 1'b0) begin
        if (q[i + c/2] !== 1'b0) ferr++;
        for (int k = 0; k < 8; k++) b[k] = q[i + c*(k+1) + c/2];
        if (q[i + 9*c + c/2] !== 1'b1) ferr++;
        rx.push_back(b);
        st.push_back(i);
        i = i + 9*c + c/2 + 1;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    int bad, bad2, bad3, nxt, e9, hi;
    logic acc, ev;
    logic [7:0] exp_b;
    logic [7:0] hello [16];
    int dl[$];
    string s;

    s = "Hello World!!!!!";
    for (int i = 0; i < 16; i++) hello[i] = s[i];

    // reset values
    #2 rst_n = 1'b0;
    #2;
    chk("rst_tx", a_tx, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_b_tx", b_tx, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // single byte 0x48
    start_rec();
    a_data = 8'h48; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("t1_cnt_e0", a_cnt, 1);
    chk("t1_tx_e0", a_tx, 1);
    repeat (321) tick();
    exp_b = 8'h48;
    bad = 0; bad2 = 0; bad3 = 0;
    for (int e = 1; e <= 321; e++) begin
      if (e <= 32)       ev = 1'b0;
      else if (e <= 288) ev = exp_b[(e-1)/32 - 1];
      else               ev = 1'b1;
      if (qa[e] !== ev) bad++;
      if (qad[e] !== 1'(e == 320)) bad2++;
      if (qab[e] !== 1'(e <= 320)) bad3++;
    end
    chk("t1_tx_e1", qa[1], 0);
    chk("t1_wave", bad, 0);
    chk("t1_done_wave", bad2, 0);
    chk("t1_busy_wave", bad3, 0);
    chk("t1_done_320", qad[320], 1);
    chk("t1_busy_321", qab[321], 0);
    decode(1'b0, 32);
    chk("t1_nbytes", rx.size(), 1);
    chk("t1_byte", (rx.size() > 0) ? rx[0] : 8'hxx, 8'h48);

    // burst into a full FIFO
    start_rec();
    nxt = 0; e9 = -1;
    while (nxt < 11 && cyc < 2000) begin
      a_valid = 1'b1;
      a_data  = 8'(nxt);
      acc     = a_ready;
      tick();
      if (acc) begin
        if (nxt == 9) e9 = cyc;
        nxt++;
      end
      if (cyc == 8) begin
        chk("t2_ready_e8", a_ready, 0);
        chk("t2_cnt_e8", a_cnt, 8);
      end
      if (cyc == 321) chk("t2_ready_e321", a_ready, 1);
    end
    a_valid = 1'b0;
    chk("t2_accepted", nxt, 11);
    chk("t2_byte9_edge", e9, 322);
    wait_idle(1'b0, 5000, "t2_idle_timeout");
    decode(1'b0, 32);
    chk("t2_nbytes", rx.size(), 11);
    bad = 0; bad2 = 0;
    for (int k = 0; k < 11; k++)
      if (k >= rx.size() || rx[k] !== 8'(k)) bad++;
    for (int k = 1; k < st.size(); k++)
      if (st[k] - st[k-1] != 320) bad2++;
    chk("t2_order", bad, 0);
    chk("t2_gap", bad2, 0);
    chk("t2_frame", ferr, 0);

    // loopback of "Hello World!!!!!"
    start_rec();
    nxt = 0;
    while (nxt < 16 && cyc < 20000) begin
      a_valid = 1'b1;
      a_data  = hello[nxt];
      acc     = a_ready;
      tick();
      if (acc) nxt++;
    end
    a_valid = 1'b0;
    wait_idle(1'b0, 8000, "t3_idle_timeout");
    decode(1'b0, 32);
    chk("t3_nbytes", rx.size(), 16);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (k >= rx.size() || rx[k] !== hello[k]) bad++;
    chk("t3_bytes", bad, 0);
    chk("t3_frame", ferr, 0);
    dl.delete();
    for (int j = 0; j < qad.size(); j++)
      if (qad[j] === 1'b1) dl.push_back(j);
    chk("t3_ndone", dl.size(), 16);
    bad = 0;
    for (int k = 1; k < dl.size(); k++)
      if (dl[k] - dl[k-1] != 320) bad++;
    chk("t3_done_gap", bad, 0);
    if (dl.size() > 0 && st.size() > 0)
      chk("t3_done_first", dl[0] - st[0], 319);

    // reset mid-frame during data bit 3 of 0x55
    start_rec();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_data  = (i == 0) ? 8'h55 : 8'(i);
      tick();
    end
    a_valid = 1'b0;
    chk("t4_cnt_queued", a_cnt, 3);
    while (cyc < 140) tick();
    chk("t4_bit3_pre", a_tx, 0);
    rst_n = 1'b0;
    #1;
    chk("t4_tx_async", a_tx, 1);
    chk("t4_cnt", a_cnt, 0);
    chk("t4_busy", a_busy, 0);
    chk("t4_ready", a_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
    end
    chk("t4_quiet", bad, 0);
    chk("t4_cnt_after", a_cnt, 0);

    // 2 clks/bit stream with pushes on pop edges
    start_rec();
    b_valid = 1'b1; b_data = 8'hA0;
    tick();
    b_valid = 1'b0;
    chk("t5_cnt_e0", b_cnt, 1);
    for (int k = 1; k < 20; k++) begin
      while (cyc < 20*(k-1)) tick();
      chk("t5_cnt_pre", b_cnt, 1);
      chk("t5_ready", b_ready, 1);
      b_valid = 1'b1;
      b_data  = 8'hA0 + 8'(k);
      tick();
      b_valid = 1'b0;
      chk("t5_cnt_post", b_cnt, 1);
    end
    wait_idle(1'b1, 200, "t5_idle_timeout");
    decode(1'b1, 2);
    chk("t5_nbytes", rx.size(), 20);
    bad = 0; bad2 = 0;
    for (int k = 0; k < 20; k++)
      if (k >= rx.size() || rx[k] !== 8'hA0 + 8'(k)) bad++;
    for (int k = 1; k < st.size(); k++)
      if (st[k] - st[k-1] != 20) bad2++;
    chk("t5_order", bad, 0);
    chk("t5_gap", bad2, 0);
    chk("t5_frame", ferr, 0);

    // minimum period, 0xFF
    start_rec();
    b_valid = 1'b1; b_data = 8'hFF;
    tick();
    b_valid = 1'b0;
    repeat (22) tick();
    bad = 0; hi = 0; bad2 = 0; bad3 = 0;
    for (int e = 1; e <= 22; e++) begin
      if (qb[e] !== 1'(e > 2)) bad++;
      if (e >= 3 && e <= 20 && qb[e] === 1'b1) hi++;
      if (qbd[e] !== 1'(e == 20)) bad2++;
      if (qbb[e] === 1'b1) bad3++;
    end
    chk("t6_wave", bad, 0);
    chk("t6_high18", hi, 18);
    chk("t6_done_wave", bad2, 0);
    chk("t6_frame_len", bad3, 20);
    decode(1'b1, 2);
    chk("t6_byte", (rx.size() > 0) ? rx[0] : 8'hxx, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
